// File: rtl/zeroriscy_mmult_wb_if.sv
// ---------------------------------------------------------------------------
// zeroriscy_mmult_wb_if
// Bus between the mmult write-back stage and its neighbours. The result
// beat handshake and the pop/flush controls share one interface.
//   master : drives res_valid_i, res_i, flush_i, rd_en_i (pipeline + core)
//   slave  : drives res_ready_o, rd_data_o, empty_o, full_o, count_o,
//            overflow_o (the write-back stage)
// Parameter DEPTH sizes count_o and must match the stage's DEPTH.
// ---------------------------------------------------------------------------
interface zeroriscy_mmult_wb_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          res_valid_i;
    logic [31:0]   res_i;
    logic          res_ready_o;
    logic          flush_i;
    logic          rd_en_i;
    logic [31:0]   rd_data_o;
    logic          empty_o;
    logic          full_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;

    modport master (
        output res_valid_i, res_i, flush_i, rd_en_i,
        input  res_ready_o, rd_data_o, empty_o, full_o, count_o, overflow_o
    );

    modport slave (
        input  res_valid_i, res_i, flush_i, rd_en_i,
        output res_ready_o, rd_data_o, empty_o, full_o, count_o, overflow_o
    );
endinterface

// File: rtl/zeroriscy_mmult_wb.sv
// ---------------------------------------------------------------------------
// zeroriscy_mmult_wb
// Write-back stage after the mmult IP8 pipeline. Each accepted beat carries
// two signed 16-bit partial sums {IP0, IP1}; both are saturated to 8 bits
// and two beats are packed into one 32-bit word:
//   [31:24]=IP0 beat1, [23:16]=IP1 beat1, [15:8]=IP0 beat0, [7:0]=IP1 beat0
// Packed words sit in a show-ahead FIFO of DEPTH words drained by the core.
//
// Ports:
//   clk    : core clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : zeroriscy_mmult_wb_if.slave (beat handshake, pop, flush,
//            FIFO status and sticky overflow flag)
//
// Configuration:
//   ZERORISCY_MMULT_WB_RELU_EN defined  -> lanes clamp to [0,127] (ReLU)
//   ZERORISCY_MMULT_WB_RELU_EN undefined -> lanes clamp to [-128,127]
// ---------------------------------------------------------------------------
module zeroriscy_mmult_wb #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    zeroriscy_mmult_wb_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {EMPTY, HALF} half_t;

    half_t       half, half_next;
    logic [15:0] lo16;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [31:0] mem [DEPTH];
    logic        overflow;

    logic        empty, full;
    logic        pop_req, ready, accept, push, pop;
    logic [15:0] sat_pair;

    function automatic logic [7:0] sat8(input logic signed [15:0] v);
`ifdef ZERORISCY_MMULT_WB_RELU_EN
        if (v < 16'sd0)        return 8'h00;
        else if (v > 16'sd127) return 8'h7F;
        else                   return v[7:0];
`else
        if (v > 16'sd127)       return 8'h7F;
        else if (v < -16'sd128) return 8'h80;
        else                    return v[7:0];
`endif
    endfunction

    assign sat_pair = {sat8(bus.res_i[31:16]), sat8(bus.res_i[15:0])};

    // Extra pointer MSB: equal low bits with differing MSBs means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot a beat 1 needs, hence the
    // intended combinational path from rd_en_i to res_ready_o.
    assign pop_req = bus.rd_en_i & ~empty;
    assign ready   = (half == EMPTY) | ~full | pop_req;
    assign accept  = bus.res_valid_i & ready;

    // Flush overrides every push and pop in its cycle.
    assign push = accept & (half == HALF) & ~bus.flush_i;
    assign pop  = pop_req & ~bus.flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) half <= EMPTY;
        else        half <= half_next;
    end

    always_comb begin
        // NOTE: the default assignment first keeps this block free of
        // inferred latches on paths that do not change state.
        half_next = half;
        if (bus.flush_i)  half_next = EMPTY;
        else if (accept)  half_next = (half == EMPTY) ? HALF : EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo16     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (bus.flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept && half == EMPTY) lo16 <= sat_pair;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (bus.res_valid_i && !ready) overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; empty_o and the zeroed read
    // path hide stale contents, so clearing it would only cost flops.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {sat_pair, lo16};
    end

    assign bus.res_ready_o = ready;
    assign bus.rd_data_o   = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
    assign bus.empty_o     = empty;
    assign bus.full_o      = full;
    assign bus.count_o     = wr_ptr - rd_ptr;
    assign bus.overflow_o  = overflow;
endmodule

// File: tb/tb_zeroriscy_mmult_wb.sv
// ---------------------------------------------------------------------------
// tb_zeroriscy_mmult_wb
// Self-checking bench for zeroriscy_mmult_wb (DEPTH=4). A queue-based
// reference model tracks packed words, the pending half word and the
// sticky overflow flag; directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_zeroriscy_mmult_wb;
    localparam int DEPTH = 4;

`ifdef ZERORISCY_MMULT_WB_RELU_EN
    localparam logic [31:0] EXP_PACK = 32'h7F00_0500;
`else
    localparam logic [31:0] EXP_PACK = 32'h7F80_05FE;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    zeroriscy_mmult_wb_if #(.DEPTH(DEPTH)) bus ();

    zeroriscy_mmult_wb #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_q[$];
    bit          m_half;
    logic [15:0] m_lo;
    bit          m_ovf;

    function automatic logic [7:0] ref_sat(input logic [15:0] raw);
        int v;
        int lo;
        v = int'($signed(raw));
`ifdef ZERORISCY_MMULT_WB_RELU_EN
        lo = 0;
`else
        lo = -128;
`endif
        if (v > 127) v = 127;
        if (v < lo)  v = lo;
        return v[7:0];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_half = 1'b0;
        m_lo   = '0;
        m_ovf  = 1'b0;
    endtask

    function automatic bit model_ready(input bit rd);
        return !m_half || (m_q.size() < DEPTH) || (rd && m_q.size() > 0);
    endfunction

    task automatic check_outputs(input string ctx);
        logic [31:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 32'h0;
        check({ctx, ".rd_data"},  bus.rd_data_o,  head);
        check({ctx, ".empty"},    bus.empty_o,    m_q.size() == 0);
        check({ctx, ".full"},     bus.full_o,     m_q.size() == DEPTH);
        check({ctx, ".count"},    bus.count_o,    32'(m_q.size()));
        check({ctx, ".overflow"}, bus.overflow_o, m_ovf);
    endtask

    // One clock cycle: drive at negedge, check ready, update model at the
    // rising edge, check registered outputs just after it.
    task automatic step(input bit valid, input logic [31:0] data, input bit rd, input bit fl);
        bit rdy;
        @(negedge clk);
        bus.res_valid_i = valid;
        bus.res_i       = data;
        bus.rd_en_i     = rd;
        bus.flush_i     = fl;
        #1;
        rdy = model_ready(rd);
        check("res_ready", bus.res_ready_o, rdy);
        @(posedge clk);
        if (fl) begin
            model_reset();
        end else begin
            if (rd && m_q.size() > 0) void'(m_q.pop_front());
            if (valid && rdy) begin
                if (!m_half) begin
                    m_lo   = {ref_sat(data[31:16]), ref_sat(data[15:0])};
                    m_half = 1'b1;
                end else begin
                    m_q.push_back({ref_sat(data[31:16]), ref_sat(data[15:0]), m_lo});
                    m_half = 1'b0;
                end
            end else if (valid) begin
                m_ovf = 1'b1;
            end
        end
        #1;
        check_outputs("cyc");
    endtask

    function automatic logic [15:0] rand_lane();
        logic [15:0] edges [8];
        edges = '{16'd127, 16'd128, 16'hFF80, 16'hFF7F, 16'd0, 16'hFFFF, 16'h7FFF, 16'h8000};
        case ($urandom_range(0, 2))
            0:       return 16'($urandom);
            1:       return 16'($signed($urandom_range(0, 600)) - 300);
            default: return edges[$urandom_range(0, 7)];
        endcase
    endfunction

    function automatic logic [31:0] rand_beat();
        return {rand_lane(), rand_lane()};
    endfunction

    task automatic check_reset_values(input string ctx);
        check({ctx, ".empty"},    bus.empty_o,     1'b1);
        check({ctx, ".full"},     bus.full_o,      1'b0);
        check({ctx, ".count"},    bus.count_o,     32'h0);
        check({ctx, ".overflow"}, bus.overflow_o,  1'b0);
        check({ctx, ".ready"},    bus.res_ready_o, 1'b1);
        check({ctx, ".rd_data"},  bus.rd_data_o,   32'h0);
    endtask

    initial begin
        logic [31:0] second;
        bus.res_valid_i = 1'b0;
        bus.res_i       = '0;
        bus.rd_en_i     = 1'b0;
        bus.flush_i     = 1'b0;
        model_reset();

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset and pack.
        step(1'b1, 32'h0005_FFFE, 1'b0, 1'b0);
        step(1'b1, 32'h0100_FF00, 1'b0, 1'b0);
        check("pack.word",  bus.rd_data_o, EXP_PACK);
        check("pack.count", bus.count_o,   32'd1);

        // Fill to full, beat 0 still accepted, beat 1 dropped.
        for (int i = 0; i < 2 * (DEPTH - 1); i++) step(1'b1, rand_beat(), 1'b0, 1'b0);
        check("fill.full", bus.full_o, 1'b1);
        step(1'b1, rand_beat(), 1'b0, 1'b0);
        step(1'b1, rand_beat(), 1'b0, 1'b0);
        check("fill.overflow", bus.overflow_o, 1'b1);
        check("fill.count",    bus.count_o,    32'd4);

        // Pop while full with a beat 1 in the same cycle.
        second = m_q[1];
        step(1'b1, rand_beat(), 1'b1, 1'b0);
        check("popfull.count", bus.count_o,   32'd4);
        check("popfull.head",  bus.rd_data_o, second);

        // Drain in order, then an extra pop on empty.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("underflow.count", bus.count_o,   32'd0);
        check("underflow.data",  bus.rd_data_o, 32'h0);

        // Flush mid-word, with a pop request in the same cycle.
        step(1'b1, rand_beat(), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("flush.overflow", bus.overflow_o, 1'b0);
        step(1'b1, 32'h0001_0002, 1'b0, 1'b0);
        step(1'b1, 32'h0003_0004, 1'b0, 1'b0);
        check("flush.word", bus.rd_data_o, 32'h0304_0102);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0, rand_beat(),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
        end

        // Reset mid-operation: 3 words buffered, overflow set, half pending.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * DEPTH + 2; i++) step(1'b1, rand_beat(), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("midrst.pre_count", bus.count_o,    32'd3);
        check("midrst.pre_ovf",   bus.overflow_o, 1'b1);
        #2;
        bus.res_valid_i = 1'b0;
        bus.rd_en_i     = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Operation resumes cleanly after reset.
        step(1'b1, 32'h0005_FFFE, 1'b0, 1'b0);
        step(1'b1, 32'h0100_FF00, 1'b0, 1'b0);
        check("postrst.word", bus.rd_data_o, EXP_PACK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
